// File: rtl/i2c_target_if.sv
// Bus-side signals of the I2C register target: the SCL/SDA pins plus the
// register-write notification and busy flag seen by the host logic.
`timescale 1ns/1ps
interface i2c_target_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport slave (
    input  scl_i,
    input  sda_i,
    output sda_o,
    output wr_strobe,
    output wr_addr,
    output wr_data,
    output busy
  );

  modport master (
    output scl_i,
    output sda_i,
    input  sda_o,
    input  wr_strobe,
    input  wr_addr,
    input  wr_data,
    input  busy
  );
endinterface

// File: rtl/i2c_target.sv
// I2C target with a 16x8 register file addressed through a byte pointer.
// Define I2C_TARGET_AUTOINC_EN to advance the pointer after every data byte.
`timescale 1ns/1ps
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h08
) (
  input  logic         clk,
  input  logic         rst_n,
  i2c_target_if.slave  bus
);

`ifdef I2C_TARGET_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_IGNORE    = 4'd9;

  logic       scl_p0, scl_p1, scl_p2;
  logic       sda_p0, sda_p1, sda_p2;
  logic       scl_rise, scl_fall, start_det, stop_det;

  logic [3:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] rx_sh;
  logic [7:0] tx_sh;
  logic [7:0] rx_next;
  logic       rw;
  logic [3:0] ptr;
  logic [7:0] regs [16];
  logic       sda_drv;
  logic       busy_q;
  logic       wr_strobe_q;
  logic [3:0] wr_addr_q;
  logic [7:0] wr_data_q;

  // Stage p0/p1: metastability synchronizers; p2: previous value for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= bus.scl_i;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= bus.sda_i;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  =  scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 &  scl_p2;
  assign start_det =  scl_p1 &  scl_p2 &  sda_p2 & ~sda_p1;
  assign stop_det  =  scl_p1 &  scl_p2 & ~sda_p2 &  sda_p1;
  assign rx_next   = {rx_sh[6:0], sda_p1};

  // Stage p3: protocol FSM, register file and pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= 4'd0;
      rx_sh       <= 8'h00;
      tx_sh       <= 8'h00;
      rw          <= 1'b0;
      ptr         <= 4'd0;
      sda_drv     <= 1'b1;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'd0;
      wr_data_q   <= 8'h00;
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe_q <= 1'b0;
      if (stop_det) begin
        state   <= S_IDLE;
        sda_drv <= 1'b1;
        busy_q  <= 1'b0;
      end else if (start_det) begin
        state   <= S_ADDR;
        bit_cnt <= 4'd0;
        sda_drv <= 1'b1;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              rx_sh   <= rx_next;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (rx_sh[7:1] == DEV_ADDR) begin
                sda_drv <= 1'b0;
                busy_q  <= 1'b1;
                rw      <= rx_sh[0];
                state   <= S_ADDR_ACK;
              end else begin
                state   <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (rw) begin
                // The fall that ends the ACK launches the MSB of the read byte
                sda_drv <= regs[ptr][7];
                tx_sh   <= {regs[ptr][6:0], 1'b0};
                state   <= S_RDATA;
              end else begin
                sda_drv <= 1'b1;
                state   <= S_PTR;
              end
            end
          end
          S_PTR: begin
            if (scl_rise) begin
              rx_sh   <= rx_next;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              ptr     <= rx_sh[3:0];
              sda_drv <= 1'b0;
              state   <= S_PTR_ACK;
            end
          end
          S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              sda_drv <= 1'b1;
              bit_cnt <= 4'd0;
              state   <= S_WDATA;
            end
          end
          S_WDATA: begin
            if (scl_rise) begin
              rx_sh   <= rx_next;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                regs[ptr]   <= rx_next;
                wr_strobe_q <= 1'b1;
                wr_addr_q   <= ptr;
                wr_data_q   <= rx_next;
                if (AUTOINC) ptr <= ptr + 4'd1;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_drv <= 1'b0;
              state   <= S_WDATA_ACK;
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_drv <= 1'b1;
                state   <= S_RDATA_ACK;
                if (AUTOINC) ptr <= ptr + 4'd1;
              end else begin
                sda_drv <= tx_sh[7];
                tx_sh   <= {tx_sh[6:0], 1'b0};
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_p1) state <= S_IGNORE;
            end else if (scl_fall) begin
              bit_cnt <= 4'd0;
              sda_drv <= regs[ptr][7];
              tx_sh   <= {regs[ptr][6:0], 1'b0};
              state   <= S_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A START/STOP must not be masked by a target still pulling SDA low.
  assign bus.sda_o     = sda_drv | start_det | stop_det;
  assign bus.busy      = busy_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged controller with open-drain SDA,
// write/read scoreboards and immediate-assertion checks.
`timescale 1ns/1ps
module tb_i2c_target;
  localparam time Q = 40ns;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

`ifdef I2C_TARGET_AUTOINC_EN
  localparam logic [3:0] SECOND_ADDR = 4'h0;
  localparam logic [7:0] FIRST_READ  = 8'h11;
`else
  localparam logic [3:0] SECOND_ADDR = 4'hF;
  localparam logic [7:0] FIRST_READ  = 8'h22;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  wr_t        exp_q[$];
  logic [7:0] rd_q[$];
  wr_t        mon_e;
  logic       ack;
  logic       rel;
  logic       s;
  logic [7:0] rd;

  i2c_target_if bus();
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & bus.sda_o;

  i2c_target #(.DEV_ADDR(7'h08)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: each wr_strobe pops the next expected register write.
  always @(negedge clk) begin
    if (bus.wr_strobe) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected_strobe", 16'(bus.wr_strobe), 16'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 16'(bus.wr_addr), 16'(mon_e.a));
        chk("wr_data", 16'(bus.wr_data), 16'(mon_e.d));
      end
    end
  end

  task automatic bit_xfer(input logic b, output logic smp);
    #Q sda_m = b;
    #Q scl_m = 1'b1;
    #Q smp = bus.sda_i;
    #Q scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    #Q sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic a);
    logic t;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], t);
    bit_xfer(1'b1, a);
  endtask

  task automatic read_byte(input logic ack_in, output logic [7:0] d, output logic ack_line);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, t);
      d[i] = t;
    end
    bit_xfer(ack_in, ack_line);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_o",     16'(bus.sda_o),     16'd1);
    chk("rst_busy",      16'(bus.busy),      16'd0);
    chk("rst_wr_strobe", 16'(bus.wr_strobe), 16'd0);
    chk("rst_wr_addr",   16'(bus.wr_addr),   16'd0);
    chk("rst_wr_data",   16'(bus.wr_data),   16'd0);
    @(negedge clk) rst_n = 1'b1;
    #(4*Q);

    // Write 0xAC to register 3
    i2c_start();
    write_byte(8'h10, ack); chk("t1_addr_ack", 16'(ack), 16'd0);
    chk("t1_busy", 16'(bus.busy), 16'd1);
    write_byte(8'h03, ack); chk("t1_ptr_ack", 16'(ack), 16'd0);
    exp_q.push_back(wr_t'{a: 4'h3, d: 8'hAC});
    write_byte(8'hAC, ack); chk("t1_data_ack", 16'(ack), 16'd0);
    i2c_stop();
    #Q;
    chk("t1_busy_after_stop", 16'(bus.busy), 16'd0);
    chk("t1_wr_pending", 16'(exp_q.size()), 16'd0);

    // Pointer write, repeated START, read with NACK
    i2c_start();
    write_byte(8'h10, ack); chk("t2_addr_w_ack", 16'(ack), 16'd0);
    write_byte(8'h03, ack); chk("t2_ptr_ack", 16'(ack), 16'd0);
    i2c_start();
    write_byte(8'h11, ack); chk("t2_addr_r_ack", 16'(ack), 16'd0);
    rd_q.push_back(8'hAC);
    read_byte(1'b1, rd, rel);
    chk("t2_rd_data", 16'(rd), 16'(rd_q.pop_front()));
    chk("t2_ack_slot_released", 16'(rel), 16'd1);
    #Q;
    chk("t2_sda_released", 16'(bus.sda_o), 16'd1);
    i2c_stop();

    // Wrong address is ignored
    i2c_start();
    write_byte(8'h12, ack); chk("t3_addr_nack", 16'(ack), 16'd1);
    chk("t3_busy", 16'(bus.busy), 16'd0);
    write_byte(8'h05, ack); chk("t3_ignored_nack", 16'(ack), 16'd1);
    i2c_stop();
    chk("t3_busy_end", 16'(bus.busy), 16'd0);

    // Pointer 15 with two data bytes (wrap or repeat depending on build)
    i2c_start();
    write_byte(8'h10, ack); chk("t4_addr_ack", 16'(ack), 16'd0);
    write_byte(8'h0F, ack); chk("t4_ptr_ack", 16'(ack), 16'd0);
    exp_q.push_back(wr_t'{a: 4'hF, d: 8'h11});
    write_byte(8'h11, ack); chk("t4_d0_ack", 16'(ack), 16'd0);
    exp_q.push_back(wr_t'{a: SECOND_ADDR, d: 8'h22});
    write_byte(8'h22, ack); chk("t4_d1_ack", 16'(ack), 16'd0);
    i2c_start();
    write_byte(8'h10, ack); chk("t4_rb_addr_ack", 16'(ack), 16'd0);
    write_byte(8'h0F, ack); chk("t4_rb_ptr_ack", 16'(ack), 16'd0);
    i2c_start();
    write_byte(8'h11, ack); chk("t4_rb_addr_r_ack", 16'(ack), 16'd0);
    rd_q.push_back(FIRST_READ);
    rd_q.push_back(8'h22);
    read_byte(1'b0, rd, rel);
    chk("t4_rd0", 16'(rd), 16'(rd_q.pop_front()));
    read_byte(1'b1, rd, rel);
    chk("t4_rd1", 16'(rd), 16'(rd_q.pop_front()));
    i2c_stop();

    // Reset while the target drives the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(((8'h10 >> i) & 8'h01) != 8'h00, s);
    for (int i = 0; i < 20 && bus.sda_o; i++) @(negedge clk);
    chk("t5_ack_driven", 16'(bus.sda_o), 16'd0);
    chk("t5_busy_before", 16'(bus.busy), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_sda_o", 16'(bus.sda_o), 16'd1);
    chk("t5_rst_busy", 16'(bus.busy), 16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bit_xfer(1'b1, s);
    chk("t5_ninth_released", 16'(s), 16'd1);
    i2c_stop();
    i2c_start();
    write_byte(8'h10, ack); chk("t5_addr_ack", 16'(ack), 16'd0);
    write_byte(8'h07, ack); chk("t5_ptr_ack", 16'(ack), 16'd0);
    exp_q.push_back(wr_t'{a: 4'h7, d: 8'h5A});
    write_byte(8'h5A, ack); chk("t5_data_ack", 16'(ack), 16'd0);
    i2c_start();
    write_byte(8'h10, ack); chk("t5_rb_addr_ack", 16'(ack), 16'd0);
    write_byte(8'h07, ack); chk("t5_rb_ptr_ack", 16'(ack), 16'd0);
    i2c_start();
    write_byte(8'h11, ack); chk("t5_rb_addr_r_ack", 16'(ack), 16'd0);
    rd_q.push_back(8'h5A);
    read_byte(1'b1, rd, rel);
    chk("t5_rd", 16'(rd), 16'(rd_q.pop_front()));
    i2c_stop();

    #(4*Q);
    chk("end_wr_pending", 16'(exp_q.size()), 16'd0);
    chk("end_busy", 16'(bus.busy), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
